instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Inverse of the instruction-decode control path. It accepts micro-op requests (NOP, ADDI, BNE) with register and immediate fields over a valid/ready handshake. It encodes each request into a 32-bit RV32I instruction word and buffers it in a small FIFO. It emits each word with a byte address for the instruction-memory loader. It feeds test programs and boot images into instruction memory, and these are later consumed by the control unit.

Parameters:
- DATA_WIDTH, 32, instruction word width; fixed at 32 for RV32I.
- ADDR_WIDTH, 8, byte-address width of out_addr.
- FIFO_DEPTH, 4, output buffer entries; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- op  in  2  00=NOP, 01=ADDI, 10=BNE, 11=reserved.
- rd  in  5  destination register (ADDI only).
- rs1  in  5  source register 1 (ADDI, BNE).
- rs2  in  5  source register 2 (BNE only).
- imm  in  13  signed immediate; ADDI uses the 12-bit value, BNE uses a 13-bit byte offset.
- err_clr  in  1  clears err.
- out_valid  out  1  out_instr and out_addr are valid.
- out_ready  in  1  loader accepts the word.
- out_instr  out  DATA_WIDTH  encoded instruction word.
- out_addr  out  ADDR_WIDTH  byte address of out_instr.
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- err  out  1  sticky flag for an illegal request.

Behaviour:
- Reset (async assert, sync deassert handled upstream): FIFO emptied; out_valid=0; out_instr=0; out_addr=0; count=0; err=0; in_ready=1.
- Input handshake: a request is accepted when in_valid && in_ready. in_ready = (count < FIFO_DEPTH). There is no push-on-pop bypass when the FIFO is full.
- Encoding, combinational then registered at push:
  - NOP -> 0x00000013 (addi x0,x0,0).
  - ADDI -> {imm[11:0], rs1, 3'b000, rd, 7'b0010011}.
  - BNE -> {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011}.
- Legality checks:
  - ADDI is illegal if imm[12] != imm[11], i.e. the value does not fit in 12 bits signed.
  - BNE is illegal if imm[0]=1.
  - op=11 is always illegal.
- Illegal request: still handshaken (consumed), not enqueued, err set to 1. count and out_addr are unchanged.
- err is sticky and is cleared by err_clr. If err_clr and a new illegal request occur in the same cycle, set wins and err=1.
- Latency: a request accepted at edge N is visible at out_valid/out_instr after edge N, in cycle N+1, when the FIFO was empty. Otherwise it follows FIFO order.
- Output: out_valid = (count != 0); out_instr is the FIFO head. It is held stable while out_valid && !out_ready.
- Address counter:
  - out_addr holds the address of the head word.
  - It increments by 4 on each out_valid && out_ready.
  - It wraps modulo 2^ADDR_WIDTH (e.g. 8'hFC -> 8'h00), with no error on wrap.
- Simultaneous push and pop (count between 1 and FIFO_DEPTH-1): count unchanged, both pointers advance.
- Pop while empty is impossible (out_valid=0). Push while full is impossible (in_ready=0).
- Reset mid-operation: all buffered words are discarded and out_addr returns to 0. There is no partial output.

Decomposition:
- Shared package riscv_pkg holds:
  - OPC_OPIMM=7'b0010011, OPC_BRANCH=7'b1100011, F3_ADDI=3'b000, F3_BNE=3'b001.
  - enc_op_t enum {ENC_NOP, ENC_ADDI, ENC_BNE, ENC_RSVD}.
  - NOP_WORD=32'h00000013.
- These constants are also used by ControlUnit decode.
- One sub-module, instr_fifo: synchronous FIFO parameterised on width and depth, with push, pop, full, empty and count. Encoding and the address counter stay in instr_encoder.

Test Plan:
- ADDI rd=5, rs1=0, imm=255, out_ready=1 -> next cycle out_valid=1, out_instr=0x0FF00293, out_addr=0x00; err=0.
- BNE rs1=1, rs2=0, imm=-8 (13'h1FF8) -> out_instr=0xFE009CE3. Then NOP -> out_instr=0x00000013 at out_addr=0x04.
- ADDI imm=2048 (13'h0800), then BNE imm=3 -> both handshaken, no out_valid, count=0, err=1. Pulse err_clr -> err=0 next cycle.
- Backpressure: out_ready=0, 5 NOP requests -> in_ready=0 after the 4th acceptance, count=4. Raise out_ready -> words at out_addr 0x00, 0x04, 0x08, 0x0C, then the 5th at 0x10.
- Wrap: 64 words drained with ADDR_WIDTH=8 -> the 64th at 0xFC, the next at 0x00.
- rst_n low for 1 cycle with count=3 and out_ready=0 -> immediately out_valid=0, count=0, out_addr=0, err=0, in_ready=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// RV32I encoding constants shared by the instruction encoder and the control unit decode.
package riscv_pkg;

  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [2:0]  F3_ADDI    = 3'b000;
  localparam logic [2:0]  F3_BNE     = 3'b001;
  localparam logic [31:0] NOP_WORD   = 32'h00000013;

  typedef enum logic [1:0] {
    ENC_NOP  = 2'b00,
    ENC_ADDI = 2'b01,
    ENC_BNE  = 2'b10,
    ENC_RSVD = 2'b11
  } enc_op_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO buffering encoded instruction words; the head reads as zero when empty.
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes NOP/ADDI/BNE micro-op requests into RV32I words and streams them with byte addresses.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  op,
  input  logic [4:0]                  rd,
  input  logic [4:0]                  rs1,
  input  logic [4:0]                  rs2,
  input  logic [12:0]                 imm,
  input  logic                        err_clr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_instr,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        err
);

  enc_op_t               op_e;
  logic                  legal;
  logic [DATA_WIDTH-1:0] word;
  logic                  full;
  logic                  empty;
  logic                  accept;
  logic                  push;
  logic                  pop;

  assign op_e = enc_op_t'(op);

  // ADDI must fit in 12 bits signed; BNE offsets must be halfword aligned.
  always_comb begin
    legal = 1'b0;
    word  = '0;
    case (op_e)
      ENC_NOP: begin
        legal = 1'b1;
        word  = NOP_WORD;
      end
      ENC_ADDI: begin
        legal = (imm[12] == imm[11]);
        word  = {imm[11:0], rs1, F3_ADDI, rd, OPC_OPIMM};
      end
      ENC_BNE: begin
        legal = !imm[0];
        word  = {imm[12], imm[10:5], rs2, rs1, F3_BNE, imm[4:1], imm[11], OPC_BRANCH};
      end
      default: begin
        legal = 1'b0;
        word  = '0;
      end
    endcase
  end

  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  instr_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (word),
    .pop   (pop),
    .dout  (out_instr),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // A new illegal request outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      out_addr <= '0;
    end else begin
      if (accept && !legal) err <= 1'b1;
      else if (err_clr)     err <= 1'b0;
      if (pop) out_addr <= out_addr + ADDR_WIDTH'(4);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with hand-computed instruction words and addresses.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [12:0] imm;
  logic        err_clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic [2:0]  count;
  logic        err;

  int checks;
  int errors;

  instr_encoder #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .err_clr   (err_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .count     (count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // One-cycle request; callers only use it while in_ready is high.
  task automatic applyStimulus(input logic [1:0] o, input logic [4:0] d, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [12:0] im);
    op       = o;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    imm      = im;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  int  pushed;
  int  popped;
  bit  done;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'b00;
    rd        = '0;
    rs1       = '0;
    rs2       = '0;
    imm       = '0;
    err_clr   = 1'b0;
    out_ready = 1'b0;

    #3;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'h0);
    checkOutput("rst_out_addr", 32'(out_addr), 32'h0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;

    // ADDI rd=5 rs1=0 imm=255
    out_ready = 1'b1;
    applyStimulus(2'b01, 5'd5, 5'd0, 5'd0, 13'd255);
    checkOutput("addi_valid", 32'(out_valid), 32'd1);
    checkOutput("addi_instr", out_instr, 32'h0FF00293);
    checkOutput("addi_addr", 32'(out_addr), 32'h00);
    checkOutput("addi_err", 32'(err), 32'd0);
    step();
    checkOutput("addi_drained", 32'(out_valid), 32'd0);
    checkOutput("addi_addr_inc", 32'(out_addr), 32'h04);

    // ADDI rd=1 rs1=2 imm=-1
    applyStimulus(2'b01, 5'd1, 5'd2, 5'd0, 13'h1FFF);
    checkOutput("addi_neg_instr", out_instr, 32'hFFF10093);
    step();

    // BNE rs1=1 rs2=0 imm=-8, then NOP
    doReset();
    applyStimulus(2'b10, 5'd0, 5'd1, 5'd0, 13'h1FF8);
    checkOutput("bne_instr", out_instr, 32'hFE009CE3);
    checkOutput("bne_addr", 32'(out_addr), 32'h00);
    applyStimulus(2'b00, 5'd0, 5'd0, 5'd0, 13'd0);
    checkOutput("nop_instr", out_instr, 32'h00000013);
    checkOutput("nop_addr", 32'(out_addr), 32'h04);
    checkOutput("nop_count", 32'(count), 32'd1);
    step();
    checkOutput("nop_drained", 32'(count), 32'd0);

    // Illegal requests
    applyStimulus(2'b01, 5'd3, 5'd4, 5'd0, 13'h0800);
    checkOutput("ill_addi_valid", 32'(out_valid), 32'd0);
    checkOutput("ill_addi_count", 32'(count), 32'd0);
    checkOutput("ill_addi_err", 32'(err), 32'd1);
    checkOutput("ill_addi_addr", 32'(out_addr), 32'h08);
    applyStimulus(2'b10, 5'd0, 5'd1, 5'd2, 13'd3);
    checkOutput("ill_bne_valid", 32'(out_valid), 32'd0);
    checkOutput("ill_bne_count", 32'(count), 32'd0);
    checkOutput("ill_bne_err", 32'(err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("err_clr", 32'(err), 32'd0);
    err_clr = 1'b1;
    applyStimulus(2'b11, 5'd0, 5'd0, 5'd0, 13'd0);
    err_clr = 1'b0;
    checkOutput("rsvd_set_wins", 32'(err), 32'd1);
    checkOutput("rsvd_count", 32'(count), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("err_clr2", 32'(err), 32'd0);

    // Backpressure: words are ADDI x0,x0,i -> (i<<20)|0x13
    doReset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(2'b01, 5'd0, 5'd0, 5'd0, 13'(i));
    checkOutput("bp_count_full", 32'(count), 32'd4);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_valid", 32'(out_valid), 32'd1);
    op       = 2'b01;
    imm      = 13'd4;
    in_valid = 1'b1;
    step();
    checkOutput("bp_rejected", 32'(count), 32'd4);
    checkOutput("bp_hold_instr", out_instr, 32'h00000013);
    out_ready = 1'b1;
    checkOutput("bp_w0", out_instr, 32'h00000013);
    checkOutput("bp_a0", 32'(out_addr), 32'h00);
    step();
    checkOutput("bp_w1", out_instr, 32'h00100013);
    checkOutput("bp_a1", 32'(out_addr), 32'h04);
    checkOutput("bp_c1", 32'(count), 32'd3);
    checkOutput("bp_ready1", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    checkOutput("bp_w2", out_instr, 32'h00200013);
    checkOutput("bp_a2", 32'(out_addr), 32'h08);
    checkOutput("bp_c2", 32'(count), 32'd3);
    step();
    checkOutput("bp_w3", out_instr, 32'h00300013);
    checkOutput("bp_a3", 32'(out_addr), 32'h0C);
    step();
    checkOutput("bp_w4", out_instr, 32'h00400013);
    checkOutput("bp_a4", 32'(out_addr), 32'h10);
    checkOutput("bp_c4", 32'(count), 32'd1);
    step();
    checkOutput("bp_empty", 32'(out_valid), 32'd0);
    checkOutput("bp_a5", 32'(out_addr), 32'h14);

    // Address wrap over 65 streamed NOPs
    doReset();
    out_ready = 1'b1;
    op        = 2'b00;
    pushed    = 0;
    popped    = 0;
    done      = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (out_valid && popped == 63) checkOutput("wrap_fc", 32'(out_addr), 32'h000000FC);
      if (out_valid && popped == 64) begin
        checkOutput("wrap_00", 32'(out_addr), 32'h00);
        done = 1'b1;
      end
      if (out_valid && out_ready) popped++;
      in_valid = (pushed < 65);
      if (in_valid && in_ready) pushed++;
      step();
    end
    in_valid = 1'b0;
    checkOutput("wrap_reached", 32'(done), 32'd1);
    repeat (5) step();
    checkOutput("wrap_final_addr", 32'(out_addr), 32'h04);
    checkOutput("wrap_final_count", 32'(count), 32'd0);

    // Reset in the middle of buffered traffic
    out_ready = 1'b0;
    applyStimulus(2'b11, 5'd0, 5'd0, 5'd0, 13'd0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 5'd0, 5'd0, 5'd0, 13'd0);
    checkOutput("mid_count3", 32'(count), 32'd3);
    checkOutput("mid_err_set", 32'(err), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_count", 32'(count), 32'd0);
    checkOutput("mid_addr", 32'(out_addr), 32'h00);
    checkOutput("mid_err", 32'(err), 32'd0);
    checkOutput("mid_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("mid_post_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
